// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a shared memory port with a bounded hold time per grant.
// Define ARB_ROUND_ROBIN_EN to break idle-state ties toward the requester not served last.
module mem_arbiter #(
    parameter int unsigned word_size = 8,
    parameter int unsigned MAX_HOLD  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [word_size-1:0] addr0,
    input  logic [word_size-1:0] wdata0,
    input  logic                 we0,
    input  logic                 req1,
    input  logic [word_size-1:0] addr1,
    input  logic [word_size-1:0] wdata1,
    input  logic                 we1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic [word_size-1:0] mem_addr,
    output logic [word_size-1:0] mem_wdata,
    output logic                 mem_write,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_idle = 2'b00,
        S_g0   = 2'b01,
        S_g1   = 2'b10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] hold_cnt;
    logic       hold_at_max;
    logic       tie_g1;

    assign hold_at_max = (hold_cnt == 4'(MAX_HOLD - 1));

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = requester 0 was served last; 0 = requester 1 was served last.
    logic last_served;
    assign tie_g1 = last_served;
`else
    assign tie_g1 = 1'b0;
`endif

    always_comb begin
        state_next = S_idle;
        case (state)
            S_idle: begin
                if (req0 && req1)  state_next = tie_g1 ? S_g1 : S_g0;
                else if (req0)     state_next = S_g0;
                else if (req1)     state_next = S_g1;
                else               state_next = S_idle;
            end
            S_g0: begin
                // Keep the grant unless the hold budget is spent and requester 1 waits.
                if (req0 && !(req1 && hold_at_max)) state_next = S_g0;
                else if (req1)                      state_next = S_g1;
                else                                state_next = S_idle;
            end
            S_g1: begin
                if (req1 && !(req0 && hold_at_max)) state_next = S_g1;
                else if (req0)                      state_next = S_g0;
                else                                state_next = S_idle;
            end
            default: state_next = S_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_idle;
            hold_cnt <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_served <= 1'b0;
`endif
        end else begin
            state <= state_next;
            gnt0  <= (state_next == S_g0);
            gnt1  <= (state_next == S_g1);
            // Counter restarts on every entry into a grant state, saturates while held.
            if (state_next == S_idle || state_next != state) begin
                hold_cnt <= 4'd0;
            end else if (!hold_at_max) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (state_next != state) begin
                if (state_next == S_g0)      last_served <= 1'b1;
                else if (state_next == S_g1) last_served <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_wdata = wdata0;
            mem_write = we0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_wdata = wdata1;
            mem_write = we1;
        end
    end

    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant latency, hold limit, handover, async reset, ties.
module tb_mem_arbiter;

    localparam int unsigned WS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [WS-1:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic          gnt0, gnt1, mem_write, busy;
    logic [WS-1:0] mem_addr, mem_wdata;

    int n_vec = 0;
    int n_bad = 0;

    mem_arbiter #(.word_size(WS), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .we0       (we0),
        .req1      (req1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .we1       (we1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_write (mem_write),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic tie2_exp_g1;
`ifdef ARB_ROUND_ROBIN_EN
        tie2_exp_g1 = 1'b1;
`else
        tie2_exp_g1 = 1'b0;
`endif
        #1 rst = 1'b1;
        #1;
        check_eq("rst_gnt0", gnt0, 0);
        check_eq("rst_gnt1", gnt1, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_write", mem_write, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);

        // Single requester 0 with a write.
        tick();
        rst = 1'b0;
        req0 = 1'b1; addr0 = 8'h12; wdata0 = 8'h34; we0 = 1'b1;
        addr1 = 8'hA5; wdata1 = 8'h5A;
        #1 check_eq("no_comb_gnt0", gnt0, 0);
        tick();
        check_eq("g0_gnt0", gnt0, 1);
        check_eq("g0_gnt1", gnt1, 0);
        check_eq("g0_mem_addr", mem_addr, 8'h12);
        check_eq("g0_mem_wdata", mem_wdata, 8'h34);
        check_eq("g0_mem_write", mem_write, 1);
        check_eq("g0_busy", busy, 1);
        repeat (6) tick();
        check_eq("g0_held", gnt0, 1);

        // Requester 1's strobe must not leak while requester 0 holds the port.
        we0 = 1'b0; we1 = 1'b1; addr1 = 8'h56;
        #1 check_eq("we1_blocked", mem_write, 0);
        check_eq("addr0_routed", mem_addr, 8'h12);
        we0 = 1'b1;
        #1 check_eq("we0_routed", mem_write, 1);

        // Hold counter already saturated: waiting requester 1 wins on the next edge.
        req1 = 1'b1;
        tick();
        check_eq("forced_gnt1", gnt1, 1);
        check_eq("forced_gnt0", gnt0, 0);
        check_eq("forced_addr", mem_addr, 8'h56);

        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_eq("idle_busy", busy, 0);
        check_eq("idle_mem_write", mem_write, 0);
        check_eq("idle_mem_addr", mem_addr, 0);

        // Both requesting continuously: 4x gnt0, 4x gnt1, 4x gnt0.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_eq($sformatf("alt_gnt0_%0d", i), gnt0, (i <= 4 || i > 8) ? 1 : 0);
            check_eq($sformatf("alt_gnt1_%0d", i), gnt1, (i > 4 && i <= 8) ? 1 : 0);
        end

        // Voluntary release hands straight over with no idle gap.
        req0 = 1'b0;
        tick();
        check_eq("handover_gnt1", gnt1, 1);
        check_eq("handover_gnt0", gnt0, 0);
        check_eq("handover_busy", busy, 1);

        // Asynchronous reset mid-grant with we1 high.
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_gnt1", gnt1, 0);
        check_eq("async_rst_mem_write", mem_write, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_mem_addr", mem_addr, 0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check_eq("held_in_rst", gnt0, 0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_gnt0", gnt0, 1);
        check_eq("post_rst_gnt1", gnt1, 0);

        // Two idle-state ties separated by an idle cycle.
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check_eq("tie1_gnt0", gnt0, 1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_eq("tie_gap_busy", busy, 0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check_eq("tie2_gnt1", gnt1, {31'd0, tie2_exp_g1});
        check_eq("tie2_gnt0", gnt0, {31'd0, ~tie2_exp_g1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter word_size, default 8: address and data width of the shared memory port.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles while the other requester waits; legal range 2..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0  input  1  requester 0 (processor control unit) wants the memory.
REQ-006 addr0, wdata0  input  word_size each  requester 0 address and write data.
REQ-007 we0  input  1  requester 0 write strobe.
REQ-008 req1, addr1, wdata1, we1  inputs  1/word_size/word_size/1  requester 1 (DMA/IO); same meanings as requester 0.
REQ-009 gnt0, gnt1  output  1 each  registered grant, one-hot or both 0.
REQ-010 mem_addr, mem_wdata  output  word_size each  address and write data driven to memory.
REQ-011 mem_write  output  1  memory write strobe.
REQ-012 busy  output  1  high whenever either grant is high.

Function
REQ-013 FSM states SHALL be S_idle, S_g0 and S_g1; gnt0=1 only in S_g0, gnt1=1 only in S_g1.
REQ-014 Grant latency: a request sampled high on edge n SHALL produce its grant after edge n (one cycle), never combinationally.
REQ-015 S_idle: req0 only -> S_g0; req1 only -> S_g1; both -> S_g0 (fixed priority, see REQ-026); neither -> stay.
REQ-016 S_gX with reqX high and the other request low: stay; grant is held indefinitely.
REQ-017 S_gX with reqX dropped: go to the other grant state if the other request is high, else S_idle; no idle gap on handover.
REQ-018 Hold counter: 4 bits; cleared on every entry into S_g0/S_g1; increments each cycle in a grant state; saturates at MAX_HOLD-1.
REQ-019 Forced release: in S_gX with hold counter == MAX_HOLD-1 and the other request high, next state SHALL be the other grant state even if reqX is still high.
REQ-020 Datapath mux (combinational from state): S_g0 -> addr0/wdata0/we0; S_g1 -> addr1/wdata1/we1; S_idle -> mem_addr=0, mem_wdata=0, mem_write=0.
REQ-021 mem_write SHALL equal weX AND gntX; a non-granted requester's we SHALL never reach memory.
REQ-022 A requester SHALL hold addr/wdata/we stable while its grant is high; the arbiter performs no latching of them.
REQ-023 Simultaneous drop of reqX and rise of the other request: handover per REQ-017 on that edge.
REQ-024 Unreachable state encoding SHALL return to S_idle on the next edge with all grants low.

Reset
REQ-025 rst high SHALL immediately force S_idle, hold counter 0, gnt0=gnt1=0, busy=0, mem_write=0, mem_addr=0, mem_wdata=0, including mid-grant; first grant possible one edge after rst falls.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN: when defined, a last-served flag (reset 0 = requester 1 last served) decides S_idle ties in favour of the requester not served last, and forced release (REQ-019) is unchanged; when undefined, S_idle ties always go to requester 0 and no last-served flag exists.

Verification
REQ-027 req0=1 alone from idle, addr0=8'h12, we0=1 -> gnt0=1 one cycle later, mem_addr=8'h12, mem_write=1; req1 never granted.
REQ-028 req0 and req1 held high continuously, MAX_HOLD=4 -> grant alternates every 4 cycles: 4x gnt0, 4x gnt1, 4x gnt0.
REQ-029 In S_g0 drop req0 while req1=1 -> gnt1=1 on the next cycle with no idle cycle; busy stays 1.
REQ-030 Assert rst mid-grant with we1=1 -> gnt1, mem_write and busy fall without waiting for clk; after release with both requests high, gnt0 granted first.
REQ-031 Tie from idle twice (both requests rise, drop, rise again): without ARB_ROUND_ROBIN_EN -> gnt0 both times; with it -> gnt0 then gnt1.
REQ-032 we1=1 while gnt0=1 -> mem_write follows we0 only; mem_addr equals addr0.
